muldiv_unit: RTL and testbench
==============================

Name: muldiv_unit

Overview:
- Iterative multiply/divide unit with architectural HI/LO registers for the MIPS datapath.
- Sits beside the register bank. It consumes the bank's two read ports (rs/rt operands).
- It returns MFHI/MFLO data toward the bank's write_data path.
- It drives the bank's secondary write-enable (muu_write_enable), so no GPR write from MFHI/MFLO occurs while a mul/div is in flight.

Parameters:
- WIDTH, 32, operand and HI/LO width; the iteration count equals WIDTH.

Ports:
- clock  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- start  in  1  request to execute op this cycle; held by upstream until accepted.
- op  in  3  operation: 000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, 110/111 no-op.
- rs_data  in  WIDTH  operand A: multiplicand, dividend, or MTHI/MTLO source.
- rt_data  in  WIDTH  operand B: multiplier or divisor.
- read_hi  in  1  MFHI in the current instruction.
- read_lo  in  1  MFLO in the current instruction; read_hi wins if both are set.
- mf_data  out  WIDTH  combinational: HI if read_hi, else LO if read_lo, else 0.
- busy  out  1  high while an iterative op is in flight.
- done  out  1  one-cycle pulse when HI/LO are updated by a mul/div.
- stall  out  1  busy && (start || read_hi || read_lo).
- muu_write_enable  out  1  equals !(busy && (read_hi || read_lo)); gates GPR writeback.
- hi  out  WIDTH  current HI register.
- lo  out  WIDTH  current LO register.

Behaviour:
- Reset (async, reset_n low): state IDLE, hi=0, lo=0, counter=0, busy=0, done=0, all internal accumulators 0. Reset mid-operation aborts the op with no HI/LO update.
- States:
  - IDLE: start accepted only here.
  - MUL: shift-add, one bit per cycle, WIDTH cycles.
  - DIV: restoring, one quotient bit per cycle, WIDTH cycles.
  - FIX: apply sign correction, write HI/LO, pulse done, return to IDLE.
- Accept (IDLE && start):
  - MULT/DIV: latch |rs|, |rt| and result-sign flags.
  - MULTU/DIVU: latch raw operands.
  - Load counter=WIDTH-1, go to MUL or DIV.
- MTHI/MTLO: write hi or lo with rs_data at that edge, stay IDLE, no busy, no done.
- No-op codes: ignored.
- start while busy: not accepted. stall is high, and upstream holds start/op/operands.
- Latency: accept at edge 0; busy high from edge 1; FIX at edge WIDTH; HI/LO valid and done=1 after edge WIDTH+1 (33 cycles for WIDTH=32). busy drops in the same cycle done rises.
- MUL result:
  - Unsigned: 2*WIDTH-bit product, HI=upper, LO=lower.
  - Signed: two's complement of the 64-bit product when operand signs differ.
- DIV result: LO=quotient, HI=remainder.
  - Signed quotient is negated if operand signs differ.
  - Remainder takes the dividend's sign (truncating division).
- Divide by zero, signed or unsigned: LO=all-ones, HI=rs_data.
  - Still takes the full latency; no exception raised.
- Signed overflow, 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0 (falls out naturally; must not be special-cased wrong).
- mf_data is always the committed HI/LO; partial results are never visible.
- MFHI/MFLO during busy: stall=1, muu_write_enable=0 until the cycle done=1. In the done cycle mf_data already shows the new values.
- HI/LO hold their values indefinitely when not written.

Optional Feature:
- MULDIV_FAST_MUL_EN
  - Defined: MULT/MULTU complete in a single-cycle combinational multiply. Accept at edge 0, HI/LO written at edge 1, done pulses in that cycle, busy never asserts for multiplies. DIV is unchanged.
  - Undefined: iterative multiply as specified above.

Decomposition:
- Shared package muldiv_pkg:
  - op codes (OP_MULT..OP_MTLO);
  - state encoding (ST_IDLE, ST_MUL, ST_DIV, ST_FIX);
  - default WIDTH constant.
- One natural sub-module: muldiv_iter_core. It holds the shared counter and the accumulator/remainder shift datapath for the MUL and DIV iterations. The top level keeps the FSM, sign handling, HI/LO and handshake outputs.

Test Plan:
- MULT rs=0xFFFFFFFD (-3), rt=7 -> done after 33 cycles, hi=0xFFFFFFFF, lo=0xFFFFFFEB; busy high exactly 32 cycles.
- MULTU rs=rt=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001.
- DIV rs=0xFFFFFFF9 (-7), rt=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. Then DIVU rs=0x12345678, rt=0 -> lo=0xFFFFFFFF, hi=0x12345678.
- Start DIV, assert read_lo at cycle 5 -> stall=1, muu_write_enable=0 until done. mf_data equals the new lo in the done cycle. A second start during busy is not accepted.
- MTHI 0xA5A5A5A5 then MFHI next cycle -> mf_data=0xA5A5A5A5, no busy. Signed DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
- Assert reset_n low at cycle 10 of a MULT -> busy=0, hi=lo=0 immediately, no done pulse. A new MULTU after release completes normally.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared definitions for the multiply/divide unit: operation codes,
// FSM state encoding and the default operand width.
package muldiv_pkg;

   localparam int MULDIV_WIDTH = 32;

   typedef enum logic [2:0] {
      OP_MULT  = 3'b000,
      OP_MULTU = 3'b001,
      OP_DIV   = 3'b010,
      OP_DIVU  = 3'b011,
      OP_MTHI  = 3'b100,
      OP_MTLO  = 3'b101
   } op_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_MUL  = 2'b01,
      ST_DIV  = 2'b10,
      ST_FIX  = 2'b11
   } state_e;

endpackage

// File: rtl/muldiv_iter_core.sv
// Iteration datapath of the multiply/divide unit: the shared step counter
// and the double-width accumulator used as {partial product, multiplier}
// for shift-add multiply and as {remainder, quotient} for restoring divide.
module muldiv_iter_core
   import muldiv_pkg::*;
#(
   parameter int WIDTH = MULDIV_WIDTH
) (
   input  logic                 clock,
   input  logic                 reset_n,
   input  logic                 load_i,
   input  logic [2*WIDTH-1:0]   accInit_i,
   input  logic [WIDTH-1:0]     operand_i,
   input  logic                 mulStep_i,
   input  logic                 divStep_i,
   output logic [2*WIDTH-1:0]   acc_o,
   output logic                 lastIter_o
);

   localparam int CW = $clog2(WIDTH);

   logic [CW-1:0]      count_q, count_d;
   logic [2*WIDTH-1:0] acc_q, acc_d;
   logic [WIDTH-1:0]   operand_q, operand_d;

   logic [WIDTH:0]     mulSum;
   logic [WIDTH:0]     divShift;
   logic [WIDTH:0]     divDiff;
   logic               divFits;

   // Multiply adds the multiplicand into the upper half when the current
   // multiplier bit is set; the carry is kept so the right shift loses nothing.
   // Divide compares {remainder, next dividend bit} against the divisor with
   // one extra bit so a zero divisor simply subtracts zero every step.
   assign mulSum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
                   + {1'b0, (acc_q[0] ? operand_q : {WIDTH{1'b0}})};
   assign divShift = acc_q[2*WIDTH-1:WIDTH-1];
   assign divDiff  = divShift - {1'b0, operand_q};
   assign divFits  = (divShift >= {1'b0, operand_q});

   assign acc_o      = acc_q;
   assign lastIter_o = (count_q == '0);

   // Next-state selection: load fresh operands, or perform one multiply or divide step.
   always_comb begin
      count_d   = count_q;
      acc_d     = acc_q;
      operand_d = operand_q;
      if (load_i) begin
         count_d   = CW'(WIDTH - 1);
         acc_d     = accInit_i;
         operand_d = operand_i;
      end else if (mulStep_i) begin
         count_d = count_q - 1'b1;
         acc_d   = {mulSum, acc_q[WIDTH-1:1]};
      end else if (divStep_i) begin
         count_d = count_q - 1'b1;
         acc_d   = {(divFits ? divDiff[WIDTH-1:0] : divShift[WIDTH-1:0]),
                    acc_q[WIDTH-2:0], divFits};
      end
   end

   // Datapath registers; reset clears everything so an aborted op leaves no residue.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         count_q   <= '0;
         acc_q     <= '0;
         operand_q <= '0;
      end else begin
         count_q   <= count_d;
         acc_q     <= acc_d;
         operand_q <= operand_d;
      end
   end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit holding the architectural HI/LO registers.
// Owns the control FSM, operand sign handling, HI/LO writeback and the
// stall / write-enable handshake toward the register bank.
// Optional macro MULDIV_FAST_MUL_EN: multiplies finish with a single-cycle
// combinational product instead of the shift-add iteration.
module muldiv_unit
   import muldiv_pkg::*;
#(
   parameter int WIDTH = MULDIV_WIDTH
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             start,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] rs_data,
   input  logic [WIDTH-1:0] rt_data,
   input  logic             read_hi,
   input  logic             read_lo,
   output logic [WIDTH-1:0] mf_data,
   output logic             busy,
   output logic             done,
   output logic             stall,
   output logic             muu_write_enable,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   state_e             state_q, state_d;
   logic [WIDTH-1:0]   hi_q, hi_d;
   logic [WIDTH-1:0]   lo_q, lo_d;
   logic               negRes_q, negRes_d;
   logic               negRem_q, negRem_d;
   logic               divZero_q, divZero_d;
   logic               opDiv_q, opDiv_d;
   logic               busy_q;
   logic               done_q;

   logic               isSigned, isMul, isDiv;
   logic [WIDTH-1:0]   opA, opB;
   logic               coreLoad, mulStep, divStep, lastIter;
   logic [2*WIDTH-1:0] coreAccInit, coreAcc, prodFix;
   logic [WIDTH-1:0]   coreOperand, quotFix, remFix;

   // Signed ops iterate on magnitudes; the sign flags captured at accept
   // restore the result sign in FIX.
   assign isSigned = (op == OP_MULT) || (op == OP_DIV);
   assign isMul    = (op == OP_MULT) || (op == OP_MULTU);
   assign isDiv    = (op == OP_DIV)  || (op == OP_DIVU);
   assign opA      = (isSigned && rs_data[WIDTH-1]) ? -rs_data : rs_data;
   assign opB      = (isSigned && rt_data[WIDTH-1]) ? -rt_data : rt_data;

   assign prodFix  = negRes_q ? -coreAcc : coreAcc;
   assign quotFix  = divZero_q ? {WIDTH{1'b1}}
                   : (negRes_q ? -coreAcc[WIDTH-1:0] : coreAcc[WIDTH-1:0]);
   assign remFix   = negRem_q ? -coreAcc[2*WIDTH-1:WIDTH] : coreAcc[2*WIDTH-1:WIDTH];

   muldiv_iter_core #(.WIDTH(WIDTH)) u_core (
      .clock      (clock),
      .reset_n    (reset_n),
      .load_i     (coreLoad),
      .accInit_i  (coreAccInit),
      .operand_i  (coreOperand),
      .mulStep_i  (mulStep),
      .divStep_i  (divStep),
      .acc_o      (coreAcc),
      .lastIter_o (lastIter)
   );

   // FSM next state, core control and HI/LO next values.
   always_comb begin
      state_d     = state_q;
      hi_d        = hi_q;
      lo_d        = lo_q;
      negRes_d    = negRes_q;
      negRem_d    = negRem_q;
      divZero_d   = divZero_q;
      opDiv_d     = opDiv_q;
      coreLoad    = 1'b0;
      coreAccInit = '0;
      coreOperand = '0;
      mulStep     = 1'b0;
      divStep     = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               if (isMul || isDiv) begin
                  negRes_d  = isSigned && (rs_data[WIDTH-1] ^ rt_data[WIDTH-1]);
                  negRem_d  = isSigned && rs_data[WIDTH-1];
                  divZero_d = isDiv && (rt_data == '0);
                  opDiv_d   = isDiv;
                  coreLoad  = 1'b1;
               end
               if (isMul) begin
`ifdef MULDIV_FAST_MUL_EN
                  coreAccInit = {{WIDTH{1'b0}}, opA} * {{WIDTH{1'b0}}, opB};
                  state_d     = ST_FIX;
`else
                  coreAccInit = {{WIDTH{1'b0}}, opB};
                  coreOperand = opA;
                  state_d     = ST_MUL;
`endif
               end else if (isDiv) begin
                  coreAccInit = {{WIDTH{1'b0}}, opA};
                  coreOperand = opB;
                  state_d     = ST_DIV;
               end else if (op == OP_MTHI) begin
                  hi_d = rs_data;
               end else if (op == OP_MTLO) begin
                  lo_d = rs_data;
               end
            end
         end
         ST_MUL: begin
            mulStep = 1'b1;
            if (lastIter) state_d = ST_FIX;
         end
         ST_DIV: begin
            divStep = 1'b1;
            if (lastIter) state_d = ST_FIX;
         end
         ST_FIX: begin
            state_d = ST_IDLE;
            if (opDiv_q) begin
               hi_d = remFix;
               lo_d = quotFix;
            end else begin
               hi_d = prodFix[2*WIDTH-1:WIDTH];
               lo_d = prodFix[WIDTH-1:0];
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // State, HI/LO and flag registers. busy rises one edge after accept and
   // falls on the edge that leaves FIX, which is the edge that raises done.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= ST_IDLE;
         hi_q      <= '0;
         lo_q      <= '0;
         negRes_q  <= 1'b0;
         negRem_q  <= 1'b0;
         divZero_q <= 1'b0;
         opDiv_q   <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         hi_q      <= hi_d;
         lo_q      <= lo_d;
         negRes_q  <= negRes_d;
         negRem_q  <= negRem_d;
         divZero_q <= divZero_d;
         opDiv_q   <= opDiv_d;
         busy_q    <= (state_q != ST_IDLE) && (state_d != ST_IDLE);
         done_q    <= (state_q == ST_FIX);
      end
   end

   assign hi               = hi_q;
   assign lo               = lo_q;
   assign busy             = busy_q;
   assign done             = done_q;
   assign mf_data          = read_hi ? hi_q : (read_lo ? lo_q : '0);
   assign stall            = busy_q && (start || read_hi || read_lo);
   assign muu_write_enable = !(busy_q && (read_hi || read_lo));

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: a vector table of mul/div results plus
// hand-written sequences for stall/write-enable, MTHI/MFHI and reset abort.
module tb_muldiv_unit;
   import muldiv_pkg::*;

   localparam int W = 32;

   logic          clock = 1'b0;
   logic          reset_n;
   logic          start;
   logic [2:0]    op;
   logic [W-1:0]  rs_data, rt_data;
   logic          read_hi, read_lo;
   logic [W-1:0]  mf_data, hi, lo;
   logic          busy, done, stall, muu_write_enable;

   int testsRun    = 0;
   int testsFailed = 0;

   typedef struct {
      logic [2:0]   op;
      logic [W-1:0] rs;
      logic [W-1:0] rt;
      logic [W-1:0] expHi;
      logic [W-1:0] expLo;
   } vec_t;

   vec_t vecs[10];

   muldiv_unit #(.WIDTH(W)) dut (
      .clock            (clock),
      .reset_n          (reset_n),
      .start            (start),
      .op               (op),
      .rs_data          (rs_data),
      .rt_data          (rt_data),
      .read_hi          (read_hi),
      .read_lo          (read_lo),
      .mf_data          (mf_data),
      .busy             (busy),
      .done             (done),
      .stall            (stall),
      .muu_write_enable (muu_write_enable),
      .hi               (hi),
      .lo               (lo)
   );

   // Free-running 10 ns clock.
   always #5 clock = ~clock;

   task automatic checkOutput(input string name, input logic [63:0] actual,
                              input logic [63:0] expected);
      testsRun++;
      if (actual !== expected) begin
         testsFailed++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   // Present one request at the falling edge; it is accepted at the next
   // rising edge and start is dropped just after.
   task automatic applyStimulus(input logic [2:0] o, input logic [W-1:0] a,
                                input logic [W-1:0] b);
      @(negedge clock);
      start   = 1'b1;
      op      = o;
      rs_data = a;
      rt_data = b;
      @(posedge clock);
      #1;
      start = 1'b0;
   endtask

   task automatic runVector(input int idx);
      int  cycles;
      int  busyCycles;
      int  expCycles;
      int  expBusy;
      bit  gotDone;
      bit  isMulOp;
      isMulOp   = (vecs[idx].op == OP_MULT) || (vecs[idx].op == OP_MULTU);
      expCycles = W + 1;
      expBusy   = W;
`ifdef MULDIV_FAST_MUL_EN
      if (isMulOp) begin
         expCycles = 1;
         expBusy   = 0;
      end
`endif
      applyStimulus(vecs[idx].op, vecs[idx].rs, vecs[idx].rt);
      cycles     = 0;
      busyCycles = busy ? 1 : 0;
      gotDone    = 1'b0;
      while (!gotDone && cycles < 100) begin
         @(posedge clock);
         #1;
         cycles++;
         if (done) gotDone = 1'b1;
         else if (busy) busyCycles++;
      end
      checkOutput($sformatf("vec%0d done seen", idx), 64'(gotDone), 64'd1);
      if (gotDone) begin
         checkOutput($sformatf("vec%0d latency", idx), 64'(cycles), 64'(expCycles));
         checkOutput($sformatf("vec%0d busy cycles", idx), 64'(busyCycles), 64'(expBusy));
         checkOutput($sformatf("vec%0d busy at done", idx), 64'(busy), 64'd0);
         checkOutput($sformatf("vec%0d hi", idx), 64'(hi), 64'(vecs[idx].expHi));
         checkOutput($sformatf("vec%0d lo", idx), 64'(lo), 64'(vecs[idx].expLo));
         @(posedge clock);
         #1;
         checkOutput($sformatf("vec%0d done pulse width", idx), 64'(done), 64'd0);
      end
   endtask

   initial begin
      int  cyc;
      bit  gotDone;
      bit  stallBad;
      bit  sawDone;

      vecs[0] = '{OP_MULT,  32'hFFFFFFFD, 32'd7,        32'hFFFFFFFF, 32'hFFFFFFEB};
      vecs[1] = '{OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
      vecs[2] = '{OP_DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD};
      vecs[3] = '{OP_DIVU,  32'h12345678, 32'd0,        32'h12345678, 32'hFFFFFFFF};
      vecs[4] = '{OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
      vecs[5] = '{OP_DIVU,  32'd100,      32'd7,        32'd2,        32'd14};
      vecs[6] = '{OP_DIV,   32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD};
      vecs[7] = '{OP_MULT,  32'h80000000, 32'd2,        32'hFFFFFFFF, 32'h00000000};
      vecs[8] = '{OP_DIV,   32'hFFFFFFF0, 32'd0,        32'hFFFFFFF0, 32'hFFFFFFFF};
      vecs[9] = '{OP_MULTU, 32'h12345678, 32'h10,       32'h00000001, 32'h23456780};

      reset_n = 1'b0;
      start   = 1'b0;
      op      = 3'b111;
      rs_data = '0;
      rt_data = '0;
      read_hi = 1'b0;
      read_lo = 1'b0;
      repeat (2) @(posedge clock);
      #1;
      checkOutput("reset hi", 64'(hi), 64'd0);
      checkOutput("reset lo", 64'(lo), 64'd0);
      checkOutput("reset busy", 64'(busy), 64'd0);
      checkOutput("reset done", 64'(done), 64'd0);
      @(negedge clock);
      reset_n = 1'b1;

      for (int i = 0; i < 10; i++) runVector(i);

      // DIV 100/7 with MFLO and a second start arriving while busy.
      applyStimulus(OP_DIV, 32'd100, 32'd7);
      repeat (4) @(posedge clock);
      @(negedge clock);
      read_lo = 1'b1;
      start   = 1'b1;
      op      = OP_MTLO;
      rs_data = 32'hDEADBEEF;
      stallBad = 1'b0;
      gotDone  = 1'b0;
      cyc      = 0;
      #1;
      if (stall !== 1'b1 || muu_write_enable !== 1'b0) stallBad = 1'b1;
      while (!gotDone && cyc < 100) begin
         @(posedge clock);
         #1;
         cyc++;
         if (done) gotDone = 1'b1;
         else if (stall !== 1'b1 || muu_write_enable !== 1'b0) stallBad = 1'b1;
      end
      checkOutput("stall seq done seen", 64'(gotDone), 64'd1);
      checkOutput("stall/we held while busy", 64'(stallBad), 64'd0);
      checkOutput("mf_data in done cycle", 64'(mf_data), 64'd14);
      checkOutput("stall in done cycle", 64'(stall), 64'd0);
      checkOutput("we in done cycle", 64'(muu_write_enable), 64'd1);
      start   = 1'b0;
      read_lo = 1'b0;
      @(posedge clock);
      #1;
      checkOutput("lo not overwritten by blocked start", 64'(lo), 64'd14);
      checkOutput("hi after stall seq", 64'(hi), 64'd2);

      // MTHI then MFHI, MTLO then both reads (HI has priority).
      applyStimulus(OP_MTHI, 32'hA5A5A5A5, 32'd0);
      read_hi = 1'b1;
      #1;
      checkOutput("MFHI after MTHI", 64'(mf_data), 64'hA5A5A5A5);
      checkOutput("MTHI busy", 64'(busy), 64'd0);
      checkOutput("MTHI done", 64'(done), 64'd0);
      read_hi = 1'b0;
      applyStimulus(OP_MTLO, 32'h0F0F0F0F, 32'd0);
      read_lo = 1'b1;
      #1;
      checkOutput("MFLO after MTLO", 64'(mf_data), 64'h0F0F0F0F);
      read_hi = 1'b1;
      #1;
      checkOutput("read_hi priority", 64'(mf_data), 64'hA5A5A5A5);
      read_hi = 1'b0;
      read_lo = 1'b0;
      #1;
      checkOutput("mf_data idle zero", 64'(mf_data), 64'd0);

      // Reset in the middle of a MULT aborts it without touching HI/LO later.
      applyStimulus(OP_MULT, 32'd5, 32'd9);
      repeat (9) @(posedge clock);
      @(negedge clock);
      reset_n = 1'b0;
      #1;
      checkOutput("abort busy", 64'(busy), 64'd0);
      checkOutput("abort hi", 64'(hi), 64'd0);
      checkOutput("abort lo", 64'(lo), 64'd0);
      @(negedge clock);
      reset_n = 1'b1;
      sawDone = 1'b0;
      for (int k = 0; k < 40; k++) begin
         @(posedge clock);
         #1;
         if (done) sawDone = 1'b1;
      end
      checkOutput("no done after abort", 64'(sawDone), 64'd0);
      checkOutput("lo held after abort", 64'(lo), 64'd0);

      vecs[0] = '{OP_MULTU, 32'd6, 32'd7, 32'd0, 32'd42};
      runVector(0);

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
